// File: rtl/pipe_scmiss_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_scmiss_seq : stack-cache read-miss fill sequencer for the E stage   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pipe_scmiss_seq #(
   parameter int DW       = 32,
   parameter int TMO_W    = 8,
   parameter int MAX_WAIT = 255
) (
   input  logic          clk,
   input  logic          reset_l,
   input  logic          inst_vld_e,
   input  logic          rs1_miss_e,
   input  logic          rs2_miss_e,
   input  logic [31:0]   rs1_addr_e,
   input  logic [31:0]   rs2_addr_e,
   input  logic          kill_e,
   input  logic          dcu_gnt,
   input  logic          iu_data_vld,
   input  logic [DW-1:0] dcu_data,
   output logic          sc_dcache_req,
   output logic [31:0]   sc_dcache_addr,
   output logic          sc_hold_e,
   output logic          rs1_fill_vld,
   output logic [DW-1:0] rs1_fill_data,
   output logic          rs2_fill_vld,
   output logic [DW-1:0] rs2_fill_data,
   output logic          sc_timeout_err
);

   localparam logic [2:0] C_IDLE  = 3'd0;
   localparam logic [2:0] C_REQ1  = 3'd1;
   localparam logic [2:0] C_WAIT1 = 3'd2;
   localparam logic [2:0] C_REQ2  = 3'd3;
   localparam logic [2:0] C_WAIT2 = 3'd4;
   localparam logic [2:0] C_DONE  = 3'd5;
   localparam logic [2:0] C_DRAIN = 3'd6;

   localparam logic [TMO_W-1:0] C_MAX_WAIT = TMO_W'(MAX_WAIT);

   logic [2:0]       state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             pend1_q, pend2_q;
   logic [31:0]      addr1_q, addr2_q;
   logic [DW-1:0]    fill1_q, fill2_q;

   logic w_miss;
   logic w_in_wait;
   logic w_tmo;
   logic w_tmo_fire;
   logic w_take1;
   logic w_take2;

   assign w_miss    = (state_q == C_IDLE) & inst_vld_e & (rs1_miss_e | rs2_miss_e) & ~kill_e;
   assign w_in_wait = (state_q == C_WAIT1) | (state_q == C_WAIT2) | (state_q == C_DRAIN);
   assign w_tmo     = (tmo_q == C_MAX_WAIT) & ~iu_data_vld;
   // A kill in WAITx diverts to DRAIN, which restarts the wait window.
   assign w_tmo_fire = w_tmo & (((state_q == C_WAIT1) | (state_q == C_WAIT2)) & ~kill_e
                                | (state_q == C_DRAIN));
   assign w_take1 = (state_q == C_WAIT1) & iu_data_vld & ~kill_e;
   assign w_take2 = (state_q == C_WAIT2) & iu_data_vld & ~kill_e;

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q <= C_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         C_IDLE: begin
            if (w_miss) state_d = rs1_miss_e ? C_REQ1 : C_REQ2;
         end
         C_REQ1: begin
            if (kill_e)       state_d = dcu_gnt ? C_DRAIN : C_IDLE;
            else if (dcu_gnt) state_d = C_WAIT1;
         end
         C_REQ2: begin
            if (kill_e)       state_d = dcu_gnt ? C_DRAIN : C_IDLE;
            else if (dcu_gnt) state_d = C_WAIT2;
         end
         C_WAIT1: begin
            if (kill_e)           state_d = iu_data_vld ? C_IDLE : C_DRAIN;
            else if (iu_data_vld) state_d = pend2_q ? C_REQ2 : C_DONE;
            else if (w_tmo)       state_d = C_IDLE;
         end
         C_WAIT2: begin
            if (kill_e)           state_d = iu_data_vld ? C_IDLE : C_DRAIN;
            else if (iu_data_vld) state_d = C_DONE;
            else if (w_tmo)       state_d = C_IDLE;
         end
         C_DONE:  state_d = C_IDLE;
         C_DRAIN: begin
            if (iu_data_vld || w_tmo) state_d = C_IDLE;
         end
         default: state_d = C_IDLE;
      endcase
   end

   always_comb begin
      sc_dcache_req  = (state_q == C_REQ1) | (state_q == C_REQ2);
      sc_dcache_addr = 32'd0;
      if (state_q == C_REQ1) sc_dcache_addr = addr1_q;
      if (state_q == C_REQ2) sc_dcache_addr = addr2_q;
      sc_hold_e    = w_miss | sc_dcache_req | w_in_wait;
      rs1_fill_vld = (state_q == C_DONE) & pend1_q & ~kill_e;
      rs2_fill_vld = (state_q == C_DONE) & pend2_q & ~kill_e;
   end

   always_comb begin
      tmo_d = tmo_q;
      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (w_in_wait) begin
         tmo_d = tmo_q + 1'b1;
      end
      err_d = err_q | w_tmo_fire;
   end

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         tmo_q   <= '0;
         err_q   <= 1'b0;
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
         addr1_q <= 32'd0;
         addr2_q <= 32'd0;
         fill1_q <= '0;
         fill2_q <= '0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
         if (w_miss) begin
            pend1_q <= rs1_miss_e;
            pend2_q <= rs2_miss_e;
            addr1_q <= rs1_addr_e;
            addr2_q <= rs2_addr_e;
         end
         if (w_take1) fill1_q <= dcu_data;
         if (w_take2) fill2_q <= dcu_data;
      end
   end

   assign rs1_fill_data  = fill1_q;
   assign rs2_fill_data  = fill2_q;
   assign sc_timeout_err = err_q;

endmodule
`default_nettype wire
